// File: rtl/wavetable_mixer_pkg.sv
// Shared audio package: default voice/table geometry, accumulator sizing
// and the mixer frame state encoding.
package wavetable_mixer_pkg;

  localparam int DEF_CHANNELS   = 4;
  localparam int DEF_SAMPLE_W   = 8;
  localparam int DEF_DEPTH_LOG2 = 8;
  localparam int DEF_PHASE_W    = 16;
  localparam int DEF_VOL_W      = 4;
  localparam int DEF_OUT_W      = 16;

  // Wide enough to sum CHANNELS full-scale products without overflow.
  function automatic int acc_width(input int sample_w, input int vol_w, input int channels);
    return sample_w + vol_w + $clog2(channels);
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ACCUM,
    DONE
  } state_t;

endpackage

// File: rtl/wavetable_rom.sv
// Synchronous-read wavetable ROM with one cycle of read latency.
// The table holds an identity ramp (entry i contains i).
module wavetable_rom
  import wavetable_mixer_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int SAMPLE_W   = DEF_SAMPLE_W
) (
  input  logic                  clk,
  input  logic [DEPTH_LOG2-1:0] addr,
  output logic [SAMPLE_W-1:0]   data
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [SAMPLE_W-1:0] mem [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_init
    assign mem[i] = SAMPLE_W'(i);
  end

  always_ff @(posedge clk) begin
    data <= mem[addr];
  end

endmodule

// File: rtl/wavetable_mixer.sv
// Multi-voice wavetable player: walks every channel once per sample_tick,
// scales each voice's table sample by its volume and emits the mixed sum.
module wavetable_mixer
  import wavetable_mixer_pkg::*;
#(
  parameter int CHANNELS   = DEF_CHANNELS,
  parameter int SAMPLE_W   = DEF_SAMPLE_W,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int PHASE_W    = DEF_PHASE_W,
  parameter int VOL_W      = DEF_VOL_W,
  parameter int OUT_W      = DEF_OUT_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sample_tick,
  input  logic [CHANNELS-1:0]           trig,
  input  logic [CHANNELS-1:0]           loop_en,
  input  logic [CHANNELS*PHASE_W-1:0]   step,
  input  logic [CHANNELS*VOL_W-1:0]     volume,
  output logic [DEPTH_LOG2-1:0]         rom_addr,
  input  logic [SAMPLE_W-1:0]           rom_data,
  output logic [OUT_W-1:0]              sample_out,
  output logic                          sample_valid,
  output logic [CHANNELS-1:0]           active,
  output logic                          busy,
  output logic                          overrun
);

  localparam int ACC_W  = acc_width(SAMPLE_W, VOL_W, CHANNELS);
  localparam int PROD_W = SAMPLE_W + VOL_W;
  localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);

  state_t state, state_next;

  logic [CH_W-1:0]    ch;
  logic [CH_W-1:0]    fetch_ch;
  logic [ACC_W-1:0]   acc;
  logic [PROD_W-1:0]  contrib;
  logic [PHASE_W:0]   phase_sum;
  logic [PHASE_W-1:0] phase    [CHANNELS];
  logic [PHASE_W-1:0] step_arr [CHANNELS];
  logic [VOL_W-1:0]   vol_arr  [CHANNELS];

  for (genvar c = 0; c < CHANNELS; c++) begin : g_unpack
    assign step_arr[c] = step[c*PHASE_W +: PHASE_W];
    assign vol_arr[c]  = volume[c*VOL_W +: VOL_W];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sample_tick) state_next = FETCH;
      FETCH:   state_next = ACCUM;
      ACCUM:   state_next = (ch == LAST_CH) ? DONE : FETCH;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // One shared multiplier and phase adder, steered by the channel index.
  always_comb begin
    contrib   = active[ch] ? PROD_W'(rom_data) * PROD_W'(vol_arr[ch]) : '0;
    phase_sum = {1'b0, phase[ch]} + {1'b0, step_arr[ch]};
    fetch_ch  = (state == IDLE) ? '0 : ch + CH_W'(1);
  end

  // rom_addr is loaded on the edge entering FETCH so data lands in ACCUM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch           <= '0;
      acc          <= '0;
      rom_addr     <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (sample_tick && state != IDLE) overrun <= 1'b1;
      if (state_next == FETCH)
        rom_addr <= trig[fetch_ch] ? '0 : phase[fetch_ch][PHASE_W-1 -: DEPTH_LOG2];
      case (state)
        IDLE: if (sample_tick) begin
          acc <= '0;
          ch  <= '0;
        end
        ACCUM: begin
          acc <= acc + ACC_W'(contrib);
          if (ch != LAST_CH) ch <= ch + CH_W'(1);
        end
        DONE: begin
          sample_out   <= OUT_W'(acc) << (OUT_W - ACC_W);
          sample_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Triggers are applied last so they override an advance or stop on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) phase[c] <= '0;
      active <= '0;
    end else begin
      if (state == ACCUM && active[ch]) begin
        if (phase_sum[PHASE_W] && !loop_en[ch]) begin
          active[ch] <= 1'b0;
          phase[ch]  <= '0;
        end else begin
          phase[ch] <= phase_sum[PHASE_W-1:0];
        end
      end
      for (int c = 0; c < CHANNELS; c++) begin
        if (trig[c]) begin
          active[c] <= 1'b1;
          phase[c]  <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_wavetable_mixer.sv
// Directed bench for wavetable_mixer with an identity ROM and a frame-level
// reference model of the voices.
module tb_wavetable_mixer;
  import wavetable_mixer_pkg::*;

  localparam int CH    = 4;
  localparam int SW    = 8;
  localparam int DL    = 8;
  localparam int PW    = 16;
  localparam int VW    = 4;
  localparam int OW    = 16;
  localparam int SHIFT = OW - (SW + VW + 2);

  logic              clk = 1'b0;
  logic              reset;
  logic              sample_tick;
  logic [CH-1:0]     trig;
  logic [CH-1:0]     loop_en;
  logic [CH*PW-1:0]  step;
  logic [CH*VW-1:0]  volume;
  logic [DL-1:0]     rom_addr;
  logic [SW-1:0]     rom_data;
  logic [OW-1:0]     sample_out;
  logic              sample_valid;
  logic [CH-1:0]     active;
  logic              busy;
  logic              overrun;

  int checks = 0;
  int errors = 0;
  int validCount = 0;

  int mPhase [CH];
  bit mActive[CH];
  int mStep  [CH];
  int mVol   [CH];
  bit mLoop  [CH];

  int            expOut[$];
  logic [CH-1:0] expActive[$];

  always #5 clk = ~clk;

  wavetable_rom #(.DEPTH_LOG2(DL), .SAMPLE_W(SW)) u_rom (
    .clk  (clk),
    .addr (rom_addr),
    .data (rom_data)
  );

  wavetable_mixer #(
    .CHANNELS(CH), .SAMPLE_W(SW), .DEPTH_LOG2(DL),
    .PHASE_W(PW), .VOL_W(VW), .OUT_W(OW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_tick  (sample_tick),
    .trig         (trig),
    .loop_en      (loop_en),
    .step         (step),
    .volume       (volume),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .active       (active),
    .busy         (busy),
    .overrun      (overrun)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic logic [CH-1:0] packActive();
    logic [CH-1:0] v;
    for (int c = 0; c < CH; c++) v[c] = mActive[c];
    return v;
  endfunction

  task automatic applyStimulus(input int c, input int stp, input int vol, input bit lp);
    step[c*PW +: PW]  = PW'(stp);
    volume[c*VW +: VW] = VW'(vol);
    loop_en[c]        = lp;
    mStep[c] = stp;
    mVol[c]  = vol;
    mLoop[c] = lp;
  endtask

  task automatic fireTrig(input logic [CH-1:0] mask);
    @(negedge clk);
    trig = mask;
    @(negedge clk);
    trig = '0;
    for (int c = 0; c < CH; c++) begin
      if (mask[c]) begin
        mActive[c] = 1'b1;
        mPhase[c]  = 0;
      end
    end
    checkOutput("activeAfterTrig", int'(active), int'(packActive()));
  endtask

  // One whole frame in plain arithmetic: identity table means the sample is
  // simply the top DL bits of the phase.
  task automatic modelFrame(input bit retrig0, output int outVal, output int addr0);
    int sum;
    int np;
    sum   = 0;
    addr0 = mPhase[0] >> (PW - DL);
    for (int c = 0; c < CH; c++) begin
      if (mActive[c]) begin
        sum += (mPhase[c] >> (PW - DL)) * mVol[c];
        np = mPhase[c] + mStep[c];
        if (np >= (1 << PW) && !mLoop[c]) begin
          mActive[c] = 1'b0;
          mPhase[c]  = 0;
        end else begin
          mPhase[c] = np % (1 << PW);
        end
      end
    end
    if (retrig0) begin
      mActive[0] = 1'b1;
      mPhase[0]  = 0;
    end
    outVal = sum * (1 << SHIFT);
  endtask

  task automatic doTick(input int retrigAt, input int extraTickAt,
                        output int lastOut, output int fetchAddr);
    int cycles;
    int mOut;
    int mAddr;
    @(negedge clk);
    sample_tick = 1'b1;
    modelFrame(retrigAt > 0, mOut, mAddr);
    expOut.push_back(mOut);
    expActive.push_back(packActive());
    @(negedge clk);
    sample_tick = 1'b0;
    cycles = 1;
    fetchAddr = int'(rom_addr);
    checkOutput("fetchAddrCh0", int'(rom_addr), mAddr);
    checkOutput("busyInFrame", int'(busy), 1);
    while (!sample_valid && cycles < 40) begin
      @(negedge clk);
      cycles++;
      trig        = (cycles == retrigAt) ? CH'(1) : '0;
      sample_tick = (cycles == extraTickAt);
    end
    checkOutput("latency", cycles, 2 * CH + 2);
    lastOut = int'(sample_out);
    @(negedge clk);
    checkOutput("validPulseWidth", int'(sample_valid), 0);
    checkOutput("holdSampleOut", int'(sample_out), lastOut);
  endtask

  always @(negedge clk) begin
    if (!reset && sample_valid) begin
      validCount++;
      if (expOut.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedValid: sample_valid=1, required 0");
      end else begin
        checkOutput("sampleOut", int'(sample_out), expOut.pop_front());
        checkOutput("activeAtValid", int'(active), int'(expActive.pop_front()));
      end
    end
  end

  initial begin
    int o;
    int a;
    int vc;
    reset       = 1'b1;
    sample_tick = 1'b0;
    trig        = '0;
    loop_en     = '0;
    step        = '0;
    volume      = '0;
    for (int c = 0; c < CH; c++) begin
      mPhase[c] = 0; mActive[c] = 1'b0; mStep[c] = 0; mVol[c] = 0; mLoop[c] = 1'b0;
    end
    #1;
    checkOutput("resetSampleOut", int'(sample_out), 0);
    checkOutput("resetValid", int'(sample_valid), 0);
    checkOutput("resetActive", int'(active), 0);
    checkOutput("resetBusy", int'(busy), 0);
    checkOutput("resetOverrun", int'(overrun), 0);
    checkOutput("resetRomAddr", int'(rom_addr), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    $display("[TB] single looped channel");
    applyStimulus(0, 'h0100, 15, 1'b1);
    fireTrig(4'b0001);
    doTick(0, 0, o, a);
    checkOutput("loopTick1", o, 0);
    doTick(0, 0, o, a);
    checkOutput("loopTick2", o, 60);

    $display("[TB] one-shot channel");
    applyStimulus(0, 'h8000, 15, 1'b0);
    fireTrig(4'b0001);
    doTick(0, 0, o, a);
    checkOutput("oneShotTick1", o, 0);
    doTick(0, 0, o, a);
    checkOutput("oneShotTick2", o, 7680);
    checkOutput("oneShotStopped", int'(active[0]), 0);
    doTick(0, 0, o, a);
    checkOutput("oneShotTick3", o, 0);

    $display("[TB] full-scale mix");
    for (int c = 0; c < CH; c++) applyStimulus(c, 'hFF00, 15, 1'b1);
    fireTrig(4'b1111);
    doTick(0, 0, o, a);
    checkOutput("fullScaleTick1", o, 0);
    doTick(0, 0, o, a);
    checkOutput("fullScaleTick2", o, 61200);

    $display("[TB] retrigger during channel 0 accumulate");
    applyStimulus(0, 'h0300, 15, 1'b1);
    for (int c = 1; c < CH; c++) applyStimulus(c, 'hFF00, 0, 1'b1);
    fireTrig(4'b0001);
    doTick(0, 0, o, a);
    checkOutput("retrigTickA", o, 0);
    doTick(2, 0, o, a);
    checkOutput("retrigTickB", o, 180);
    doTick(0, 0, o, a);
    checkOutput("retrigFetchAddr", a, 0);
    checkOutput("retrigTickC", o, 0);

    $display("[TB] overrun");
    checkOutput("overrunBefore", int'(overrun), 0);
    vc = validCount;
    doTick(0, 3, o, a);
    repeat (15) @(negedge clk);
    checkOutput("overrunSingleValid", validCount - vc, 1);
    checkOutput("overrunSet", int'(overrun), 1);
    doTick(0, 0, o, a);
    checkOutput("overrunSticky", int'(overrun), 1);

    $display("[TB] reset mid-frame");
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("midResetSampleOut", int'(sample_out), 0);
    checkOutput("midResetValid", int'(sample_valid), 0);
    checkOutput("midResetActive", int'(active), 0);
    checkOutput("midResetBusy", int'(busy), 0);
    checkOutput("midResetOverrun", int'(overrun), 0);
    checkOutput("midResetRomAddr", int'(rom_addr), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < CH; c++) begin
      mPhase[c] = 0;
      mActive[c] = 1'b0;
    end
    expOut.delete();
    expActive.delete();
    vc = validCount;
    repeat (25) @(negedge clk);
    checkOutput("noValidAfterReset", validCount - vc, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
